// File: rtl/share_decoder.sv
// share_decoder: serial recombination of D Boolean (XOR) shares of a W-bit
// word. Shares are captured in one edge and folded into an accumulator one
// share per clock, so the full unmasked value only appears after the last
// share has been consumed. out/DecDone are registered and zero except in DONE.
// Optional feature: define DEC_REFRESH_EN to re-randomise the shares with rin
// at the capture edge (sum of shares unchanged).
module share_decoder #(
  parameter int D = 3,
  parameter int W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [0:D*W-1]                    sh_in,
  input  logic [0:((D > 1) ? (D-1) : 1)*W-1] rin,
  input  logic                              DecEnable,
  output logic                              DecDone,
  output logic [W-1:0]                      out
);

  localparam int CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sh_q [D];
  logic [W-1:0]   sh_d [D];
  logic [W-1:0]   cap_sh [D];
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic [W-1:0]   out_q, out_d;
  logic [W-1:0]   cur_sh;
  logic [W-1:0]   acc_step;
  logic           unused_rin;

`ifdef DEC_REFRESH_EN
  // Refresh: mask shares 0..D-2 with rin words, fold the XOR of all rin
  // words into the last share so the recombined value is preserved.
  if (D > 1) begin : g_refresh
    logic [W-1:0] rin_xor;

    // XOR of every rin word, applied to the last share.
    always_comb begin
      rin_xor = '0;
      for (int i = 0; i < D-1; i++) begin
        rin_xor = rin_xor ^ rin[i*W +: W];
      end
    end

    for (genvar gi = 0; gi < D; gi++) begin : g_cap
      if (gi < D-1) begin : g_mid
        assign cap_sh[gi] = sh_in[gi*W +: W] ^ rin[gi*W +: W];
      end else begin : g_last
        assign cap_sh[gi] = sh_in[gi*W +: W] ^ rin_xor;
      end
    end
    assign unused_rin = 1'b0;
  end else begin : g_single
    // A single share cannot be refreshed; rin has no role here.
    assign cap_sh[0]  = sh_in[0 +: W];
    assign unused_rin = ^rin;
  end
`else
  // Shares are captured exactly as presented; rin is not used.
  for (genvar gi = 0; gi < D; gi++) begin : g_cap
    assign cap_sh[gi] = sh_in[gi*W +: W];
  end
  assign unused_rin = ^rin;
`endif

  // Select the share addressed by cnt (compare-based mux, no out-of-range index).
  always_comb begin
    cur_sh = '0;
    for (int i = 0; i < D; i++) begin
      if (cnt_q == CW'(i)) begin
        cur_sh = sh_q[i];
      end
    end
  end

  assign acc_step = acc_q ^ cur_sh;

  // Next-state and datapath control for IDLE -> ACC -> DONE.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    out_d   = out_q;

    case (state_q)
      IDLE: begin
        if (DecEnable) begin
          sh_d  = cap_sh;
          acc_d = cap_sh[0];
          cnt_d = CW'(1);
          if (D > 1) begin
            state_d = ACC;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            out_d   = cap_sh[0];
          end
        end
      end

      ACC: begin
        if (!DecEnable) begin
          // Abort: discard the partial result and zeroise everything.
          state_d = IDLE;
          for (int i = 0; i < D; i++) sh_d[i] = '0;
          acc_d  = '0;
          cnt_d  = '0;
          done_d = 1'b0;
          out_d  = '0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(D-1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            out_d   = acc_step;
          end
        end
      end

      DONE: begin
        if (!DecEnable) begin
          state_d = IDLE;
          for (int i = 0; i < D; i++) sh_d[i] = '0;
          acc_d  = '0;
          cnt_d  = '0;
          done_d = 1'b0;
          out_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
        for (int i = 0; i < D; i++) sh_d[i] = '0;
        acc_d  = '0;
        cnt_d  = '0;
        done_d = 1'b0;
        out_d  = '0;
      end
    endcase
  end

  // State and datapath registers; reset overrides any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < D; i++) sh_q[i] <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign DecDone = done_q;
  assign out     = out_q;

endmodule

// File: tb/tb_share_decoder.sv
// Bench for share_decoder: a D=3/W=8 instance exercised by directed and
// random operations, plus a D=1 instance. Expected results come from a
// reference model: result = XOR of all shares, DecDone after D-1 edges.
module tb_share_decoder;

  localparam int D3 = 3;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [0:23]     sh3;
  logic [0:15]     rin3;
  logic            en3;
  logic            done3;
  logic [7:0]      out3;
  logic [0:7]      sh1;
  logic [0:7]      rin1;
  logic            en1;
  logic            done1;
  logic [7:0]      out1;

  int checks = 0;
  int errors = 0;

  share_decoder #(.D(D3), .W(W)) u3 (
    .clk      (clk),
    .rst      (rst),
    .sh_in    (sh3),
    .rin      (rin3),
    .DecEnable(en3),
    .DecDone  (done3),
    .out      (out3)
  );

  share_decoder #(.D(1), .W(W)) u1 (
    .clk      (clk),
    .rst      (rst),
    .sh_in    (sh1),
    .rin      (rin1),
    .DecEnable(en1),
    .DecDone  (done1),
    .out      (out1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain XOR over the list of shares.
  function automatic logic [7:0] model_xor(input logic [7:0] s [3]);
    logic [7:0] r;
    r = 8'h00;
    foreach (s[i]) r = r ^ s[i];
    return r;
  endfunction

  // One operation on the D=3 instance. abort_at = edges after capture at
  // which DecEnable is dropped (-1: never, only after hold cycles in DONE).
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input int hold, input int abort_at);
    logic [7:0] s [3];
    logic [7:0] exp;
    int total;
    bit aborted;
    s[0] = a; s[1] = b; s[2] = c;
    exp = model_xor(s);
    total = (D3 - 1) + hold;
    aborted = 0;
    sh3  = {a, b, c};
    rin3 = 16'($urandom);
    en3  = 1'b1;
    step();
    // Inputs after the capture edge must not matter.
    sh3  = 24'($urandom);
    rin3 = 16'($urandom);
    for (int k = 0; k <= total; k++) begin
      check($sformatf("%s k%0d done", name, k), 32'(done3), 32'(k >= D3 - 1));
      check($sformatf("%s k%0d out", name, k), 32'(out3), (k >= D3 - 1) ? 32'(exp) : 32'h0);
      if (k == abort_at) begin
        aborted = 1;
        break;
      end
      if (k < total) step();
    end
    en3 = 1'b0;
    step();
    check($sformatf("%s drop done", name), 32'(done3), 32'h0);
    check($sformatf("%s drop out", name), 32'(out3), 32'h0);
    step();
    check($sformatf("%s idle done", name), 32'(done3), 32'h0);
    check($sformatf("%s idle out", name), 32'(out3), 32'h0);
    $display("op %s shares %02h %02h %02h exp %02h hold %0d abort %0d -> %s",
             name, a, b, c, exp, hold, abort_at, aborted ? "aborted" : "completed");
  endtask

  initial begin
    rst = 1'b1; en3 = 1'b0; en1 = 1'b0;
    sh3 = '0; rin3 = '0; sh1 = '0; rin1 = '0;
    step();
    step();
    check("reset done3", 32'(done3), 32'h0);
    check("reset out3",  32'(out3),  32'h0);
    check("reset done1", 32'(done1), 32'h0);
    check("reset out1",  32'(out1),  32'h0);
    rst = 1'b0;
    step();
    check("idle done3", 32'(done3), 32'h0);

    // Directed cases.
    run_op("t1", 8'h5A, 8'h3C, 8'h00, 4, -1);
    run_op("t2", 8'hFF, 8'hFF, 8'h12, 1, -1);
    run_op("t4abort", 8'h11, 8'h22, 8'h44, 3, 1);
    run_op("t4redo", 8'h01, 8'h02, 8'h04, 2, -1);
    run_op("abort0", 8'h80, 8'h08, 8'hF0, 3, 0);

    // Reset while in ACC.
    sh3 = {8'hAB, 8'hCD, 8'hEF}; en3 = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    check("rst acc done", 32'(done3), 32'h0);
    check("rst acc out",  32'(out3),  32'h0);
    rst = 1'b0; en3 = 1'b0;
    step();
    check("rst acc idle", 32'(done3), 32'h0);
    $display("op rst-in-ACC -> done %0b out %02h", done3, out3);

    // Reset while in DONE with DecEnable still high.
    sh3 = {8'h0F, 8'hF0, 8'h33}; en3 = 1'b1;
    step(); step(); step();
    check("pre-rst done", 32'(done3), 32'h1);
    check("pre-rst out",  32'(out3),  32'hCC);
    rst = 1'b1;
    step();
    check("rst done done", 32'(done3), 32'h0);
    check("rst done out",  32'(out3),  32'h0);
    rst = 1'b0; en3 = 1'b0;
    step();
    check("rst done idle", 32'(out3), 32'h0);
    $display("op rst-in-DONE -> done %0b out %02h", done3, out3);

    // D=1: result available at the capture edge.
    sh1 = 8'hC3; rin1 = 8'($urandom); en1 = 1'b1;
    step();
    check("d1 done", 32'(done1), 32'h1);
    check("d1 out",  32'(out1),  32'hC3);
    sh1 = 8'h3C;
    step();
    check("d1 hold out", 32'(out1), 32'hC3);
    en1 = 1'b0;
    step();
    check("d1 drop done", 32'(done1), 32'h0);
    check("d1 drop out",  32'(out1),  32'h0);
    $display("op D1 share c3 -> dropped, done %0b out %02h", done1, out1);

    // Random operations, some aborted part-way.
    for (int n = 0; n < 25; n++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_op($sformatf("r%0d", n), 8'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
